pipelined_adder: RTL
====================

Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the 4-bit ripple-carry adder.
- WIDTH-bit add/subtract split into STAGES carry-chained slices, with one slice per pipeline stage.
- Valid/ready handshake on input and output; throughput is one operation per cycle.
- Sits between operand producers and any consumer that needs sum, carry and signed overflow, e.g. an ALU datapath or accumulator.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and slice count; slice width CW = WIDTH/STAGES, CW >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, mod 2^WIDTH.
- cout  output  1  carry-out of MSB; in sub mode 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Single clock domain. Reset is synchronous and active-low on rst_n. While rst_n=0 at a clock edge, all stage valids and out_valid clear to 0, and sum, cout and ovf clear to 0. Pipeline data registers also clear. in_ready is 1 during and after reset.
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Global advance: adv = !out_valid || out_ready. in_ready = adv, combinational from out_valid/out_ready only, with no dependence on in_valid.
- When adv=0, every pipeline register, including the outputs, holds. Output data must stay stable while out_valid=1 and out_ready=0.
- When adv=1, each stage shifts forward. A bubble (valid=0) enters stage 0 if in_valid=0. Bubbles propagate and are never presented: out_valid=0 for them.
- Stage k (0..STAGES-1) computes slice k: bits [k*CW +: CW] of A and B_eff = sub ? ~b : b, plus the carry from stage k-1.
  - Stage 0 carry-in is sub ? 1 : cin.
  - Unprocessed higher operand bits travel in skew registers with the op. Finished lower sum bits travel in de-skew registers. Each in-flight op keeps its own sub flag and carry.
- Latency: an op accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles, when no stalls occur. Each stall cycle adds one cycle.
- Final stage: cout = carry out of bit WIDTH-1; ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Ordering: strictly FIFO. No op is dropped or duplicated.
- Simultaneous events: output transfer and input transfer in the same cycle are both legal and give full throughput.
- STAGES=1 degenerates to a single registered adder with latency 1.
- Reset mid-operation: all in-flight ops are discarded and out_valid=0 on the cycle after the reset edge.
- Input signals are don't-care when in_valid=0. X on a or b with in_valid=0 must not propagate to valid outputs.

Decomposition:
- Shared constants file holds the defaults for WIDTH and STAGES, plus a derived CW localparam computed in-module.
- One natural sub-module, adder_slice: a combinational CW-bit ripple-carry slice built from fulladder cells.
  - Ports: s[CW], cout, c_msb_in (carry into MSB, needed for ovf), a[CW], b[CW], cin.
  - Instantiated STAGES times via generate.
- Pipeline registers and handshake live in pipelined_adder.

Test Plan:
- All tests use WIDTH=16, STAGES=4.
- Reset, then a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 -> 4 cycles later sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0. sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Back-to-back ops 1+1, 2+2, 3+3, 4+4, 5+5 with out_ready=0 for 3 cycles once out_valid rises:
  - during the stall, in_ready=0 and sum=0x0002 stays stable;
  - afterwards 2,4,6,8,10 are delivered in order, one per cycle, with none lost.
- Alternating in_valid (bubbles), mixed sub and cin=1 per op -> each result matches the reference model, out_valid shows gaps matching the bubbles, and each op keeps its own sub/cin.
- Assert rst_n=0 for one edge with 3 ops in flight -> next cycle out_valid=0 and sum/cout/ovf=0. A new op issued afterwards returns correctly after 4 cycles.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// rtl/pipelined_adder_pkg.sv - shared defaults for the pipelined adder
package pipelined_adder_pkg;

    localparam int PA_WIDTH  = 16;
    localparam int PA_STAGES = 4;

endpackage

// File: rtl/pipelined_adder_slice.sv
// rtl/pipelined_adder_slice.sv - combinational ripple-carry slice built from full-adder cells
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module adder_slice #(
    parameter int CW = 4
) (
    output logic [CW-1:0] s,
    output logic          cout,
    output logic          c_msb_in,
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin
);

    logic [CW:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < CW; i++) begin : g_fa
        fulladder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_c[i]),
            .s    (s[i]),
            .cout (w_c[i+1])
        );
    end

    // The carry into the top cell is exposed so the final slice can form signed overflow.
    assign cout     = w_c[CW];
    assign c_msb_in = w_c[CW-1];

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - WIDTH-bit add/subtract split into STAGES carry-chained pipeline slices
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = PA_WIDTH,
    parameter int STAGES = PA_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = WIDTH / STAGES;

    // Per-stage state: operand skew (unprocessed high bits, right-aligned so the
    // next slice always reads bits [CW-1:0]), de-skewed partial sum, carry, valid.
    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic [STAGES-1:0] r_c;
    logic [STAGES-1:0] r_v;
    logic              r_ovf;

    logic [CW-1:0]     w_sa  [STAGES];
    logic [CW-1:0]     w_sb  [STAGES];
    logic [CW-1:0]     w_s   [STAGES];
    logic              w_cm  [STAGES];
    logic [STAGES-1:0] w_ci;
    logic [STAGES-1:0] w_co;
    logic [STAGES-1:0] w_vin;
    logic [WIDTH-1:0]  w_b_eff;
    logic              w_adv;

    // The whole pipe moves together; a stalled output freezes every stage.
    assign w_adv     = !r_v[STAGES-1] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v[STAGES-1];
    assign sum       = r_sum[STAGES-1];
    assign cout      = r_c[STAGES-1];
    assign ovf       = r_ovf;

    // Select slice operands: stage 0 reads the ports, later stages read the skew registers.
    always_comb begin
        w_b_eff  = sub ? ~b : b;
        w_sa[0]  = a[CW-1:0];
        w_sb[0]  = w_b_eff[CW-1:0];
        w_ci[0]  = sub | cin;
        w_vin[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_sa[k]  = r_a[k-1][CW-1:0];
            w_sb[k]  = r_b[k-1][CW-1:0];
            w_ci[k]  = r_c[k-1];
            w_vin[k] = r_v[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(
            .CW (CW)
        ) u_slice (
            .s        (w_s[k]),
            .cout     (w_co[k]),
            .c_msb_in (w_cm[k]),
            .a        (w_sa[k]),
            .b        (w_sb[k]),
            .cin      (w_ci[k])
        );
    end

    // Advance the pipeline; data registers only load behind a valid op so that
    // garbage on idle inputs never reaches the presented result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
            end
            r_c   <= '0;
            r_v   <= '0;
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_v <= w_vin;
            if (w_vin[0]) begin
                r_a[0]   <= a >> CW;
                r_b[0]   <= w_b_eff >> CW;
                r_sum[0] <= WIDTH'(w_s[0]);
                r_c[0]   <= w_co[0];
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_vin[k]) begin
                    r_a[k]   <= r_a[k-1] >> CW;
                    r_b[k]   <= r_b[k-1] >> CW;
                    r_sum[k] <= r_sum[k-1] | (WIDTH'(w_s[k]) << (k * CW));
                    r_c[k]   <= w_co[k];
                end
            end
            if (w_vin[STAGES-1]) begin
                r_ovf <= w_cm[STAGES-1] ^ w_co[STAGES-1];
            end
        end
    end

endmodule
